// File: rtl/key_load_ctrl.sv
// key_load_ctrl
// Bit-serial key loader for the 32-bit keyIn_0_* bus of an RLL-locked netlist.
// A key is shifted in LSB first, followed by one even-parity bit. The key bus
// is released only after a load whose key bits XOR parity bit equals 0. Until
// then the bus reads all-zero. After MAX_ATTEMPTS failed loads the block locks
// out until reset.
//
// Handshake: a serial bit transfers on a rising edge where ser_valid and
// ser_ready are both 1. ser_ready is 1 only in SHIFT. ser_valid outside SHIFT
// is dropped. The source may hold ser_valid low for any number of cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   load_start in   one-cycle request to begin a load (IDLE / ERROR only)
//   ser_valid  in   serial bit present on ser_data
//   ser_data   in   serial bit: key bits LSB first, then parity
//   ser_ready  out  loader accepts a bit this cycle
//   key_out    out  verified key, 0 unless LOCKED
//   key_valid  out  key_out holds a verified key
//   key_error  out  last load failed its parity check
//   lockout    out  attempt budget exhausted
//   busy       out  loader in SHIFT or CHECK
//   dbg_state  out  current FSM state encoding (debug observation)
module key_load_ctrl #(
  parameter int KEY_WIDTH    = 32,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  output logic                 ser_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 key_error,
  output logic                 lockout,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(KEY_WIDTH + 1);
  localparam int AW = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;
  localparam logic [2:0] S_DEAD   = 3'd5;

  logic [2:0]           r_state;
  logic [KEY_WIDTH-1:0] r_shift;
  logic [CW-1:0]        r_cnt;
  logic                 r_parity;
  logic [AW-1:0]        r_attempts;
  logic [KEY_WIDTH-1:0] r_key_out;
  logic                 r_key_valid;
  logic                 r_key_error;
  logic                 r_lockout;

  logic [KEY_WIDTH-1:0] w_shift_next;
  logic                 w_pass;
  logic [AW-1:0]        w_attempts_inc;

  // Write the incoming bit at the position selected by the bit counter.
  always_comb begin
    w_shift_next = r_shift;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (r_cnt == CW'(i)) w_shift_next[i] = ser_data;
    end
  end

  // Even parity: key bits together with the parity bit must XOR to 0.
  assign w_pass         = ~(^r_shift ^ r_parity);
  assign w_attempts_inc = r_attempts + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_parity    <= 1'b0;
      r_attempts  <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_key_error <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_valid) begin
            // Counter stops at KEY_WIDTH: that slot is the parity bit.
            if (r_cnt == CW'(KEY_WIDTH)) begin
              r_parity <= ser_data;
              r_state  <= S_CHECK;
            end else begin
              r_shift <= w_shift_next;
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        S_CHECK: begin
          if (w_pass) begin
            r_key_out   <= r_shift;
            r_key_valid <= 1'b1;
            r_state     <= S_LOCKED;
          end else begin
            r_attempts  <= w_attempts_inc;
            r_key_error <= 1'b1;
            if (w_attempts_inc == AW'(MAX_ATTEMPTS)) begin
              r_lockout <= 1'b1;
              r_state   <= S_DEAD;
            end else begin
              r_state <= S_ERROR;
            end
          end
        end
        S_ERROR: begin
          if (load_start) begin
            r_key_error <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_state     <= S_SHIFT;
          end
        end
        S_LOCKED: r_state <= S_LOCKED;
        S_DEAD:   r_state <= S_DEAD;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_ready = (r_state == S_SHIFT);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_CHECK);
  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign key_error = r_key_error;
  assign lockout   = r_lockout;
  assign dbg_state = r_state;

endmodule
